// File: rtl/coherence_bus_responder.sv
// coherence_bus_responder
// Bus-side agent answering a cache controller's request strobes.
//   Cache_Sector_Fill -> FILL: READ_DONE after READ_LAT cycles, or send_abort on abort_req
//   Invalidate        -> INV : peer_inv broadcast, AllInvDone once all peers ack or on timeout
//   AdrRetry          -> WB  : write_back_done after WB_LAT cycles
// Ports:
//   clk, reset (sync, active low)
//   Cache_Sector_Fill, Invalidate, AdrRetry : request strobes
//   abort_req                               : bus abort, used only in FILL
//   inv_ack[NUM_PEERS]                      : per-peer invalidate acknowledge
//   bus_snoop_rd, bus_snoop_wr              : observed foreign bus traffic
//   READ_DONE, send_abort, AllInvDone, write_back_done : one-cycle completions
//   SHR, SHW                                : registered snoop strobes
//   peer_inv[NUM_PEERS]                     : per-peer invalidate request level
//   busy                                    : state is not IDLE
//   inv_timeout                             : sticky, an invalidation timed out
module coherence_bus_responder #(
  parameter int unsigned READ_LAT    = 4,
  parameter int unsigned WB_LAT      = 3,
  parameter int unsigned NUM_PEERS   = 2,
  parameter int unsigned INV_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Cache_Sector_Fill,
  input  logic                 Invalidate,
  input  logic                 AdrRetry,
  input  logic                 abort_req,
  input  logic [NUM_PEERS-1:0] inv_ack,
  input  logic                 bus_snoop_rd,
  input  logic                 bus_snoop_wr,
  output logic                 READ_DONE,
  output logic                 send_abort,
  output logic                 AllInvDone,
  output logic                 write_back_done,
  output logic                 SHR,
  output logic                 SHW,
  output logic [NUM_PEERS-1:0] peer_inv,
  output logic                 busy,
  output logic                 inv_timeout
);

  typedef enum logic [1:0] {IDLE, FILL, INV, WB} state_t;

  state_t               state;
  logic [2:0]           pend;      // {wb, inv, fill}
  logic [3:0]           cnt;       // shared FILL/WB latency counter
  logic [7:0]           tcnt;      // INV timeout counter
  logic [NUM_PEERS-1:0] acks;

  logic [2:0]           live;
  logic [2:0]           cand;
  logic [2:0]           win;
  logic [NUM_PEERS-1:0] acks_next;
  logic                 all_acked;

  always_comb begin
    live      = {AdrRetry, Invalidate, Cache_Sector_Fill};
    cand      = live | pend;
    win       = '0;
    if (cand[2])      win = 3'b100;
    else if (cand[1]) win = 3'b010;
    else if (cand[0]) win = 3'b001;
    acks_next = acks | inv_ack;
    all_acked = &acks_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      pend            <= '0;
      cnt             <= '0;
      tcnt            <= '0;
      acks            <= '0;
      READ_DONE       <= 1'b0;
      send_abort      <= 1'b0;
      AllInvDone      <= 1'b0;
      write_back_done <= 1'b0;
      SHR             <= 1'b0;
      SHW             <= 1'b0;
      peer_inv        <= '0;
      busy            <= 1'b0;
      inv_timeout     <= 1'b0;
    end else begin
      READ_DONE       <= 1'b0;
      send_abort      <= 1'b0;
      AllInvDone      <= 1'b0;
      write_back_done <= 1'b0;
      // Write snoop dominates a simultaneous read snoop.
      SHW             <= bus_snoop_wr;
      SHR             <= bus_snoop_rd & ~bus_snoop_wr;
      // Outside IDLE every live strobe, even on the completion edge, is remembered.
      pend            <= pend | live;

      unique case (state)
        IDLE: begin
          pend <= cand & ~win;
          if (win[2]) begin
            state <= WB;
            cnt   <= 4'(WB_LAT);
            busy  <= 1'b1;
          end else if (win[1]) begin
            state    <= INV;
            peer_inv <= '1;
            acks     <= '0;
            tcnt     <= 8'(INV_TIMEOUT);
            busy     <= 1'b1;
          end else if (win[0]) begin
            state <= FILL;
            cnt   <= 4'(READ_LAT);
            busy  <= 1'b1;
          end
        end
        FILL: begin
          if (abort_req) begin
            send_abort <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else if (cnt == 4'd1) begin
            READ_DONE <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WB: begin
          if (cnt == 4'd1) begin
            write_back_done <= 1'b1;
            state           <= IDLE;
            busy            <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        INV: begin
          acks <= acks_next;
          // A last ack on the timeout edge counts as a normal completion.
          if (all_acked) begin
            AllInvDone <= 1'b1;
            peer_inv   <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
          end else if (tcnt == 8'd1) begin
            AllInvDone  <= 1'b1;
            inv_timeout <= 1'b1;
            peer_inv    <= '0;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            peer_inv <= ~acks_next;
            tcnt     <= tcnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_responder.sv
// Directed, table-driven bench for coherence_bus_responder (default parameters).
module tb_coherence_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       Cache_Sector_Fill, Invalidate, AdrRetry, abort_req;
  logic [1:0] inv_ack;
  logic       bus_snoop_rd, bus_snoop_wr;
  logic       READ_DONE, send_abort, AllInvDone, write_back_done;
  logic       SHR, SHW, busy, inv_timeout;
  logic [1:0] peer_inv;

  coherence_bus_responder #(
    .READ_LAT(4), .WB_LAT(3), .NUM_PEERS(2), .INV_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset),
    .Cache_Sector_Fill(Cache_Sector_Fill), .Invalidate(Invalidate),
    .AdrRetry(AdrRetry), .abort_req(abort_req), .inv_ack(inv_ack),
    .bus_snoop_rd(bus_snoop_rd), .bus_snoop_wr(bus_snoop_wr),
    .READ_DONE(READ_DONE), .send_abort(send_abort), .AllInvDone(AllInvDone),
    .write_back_done(write_back_done), .SHR(SHR), .SHW(SHW),
    .peer_inv(peer_inv), .busy(busy), .inv_timeout(inv_timeout)
  );

  always #5 clk = ~clk;

  // Input vector: {reset, fill, inv, adr, abort, ack[1], ack[0], snoop_rd, snoop_wr}
  localparam logic [8:0] R     = 9'h100;
  localparam logic [8:0] I_FIL = 9'h080;
  localparam logic [8:0] I_INV = 9'h040;
  localparam logic [8:0] I_ADR = 9'h020;
  localparam logic [8:0] I_ABT = 9'h010;
  localparam logic [8:0] I_AK1 = 9'h008;
  localparam logic [8:0] I_AK0 = 9'h004;
  localparam logic [8:0] I_SRD = 9'h002;
  localparam logic [8:0] I_SWR = 9'h001;
  // Expected: {READ_DONE, send_abort, AllInvDone, write_back_done, SHR, SHW, peer_inv[1:0], busy, inv_timeout}
  localparam logic [9:0] Z     = 10'h000;
  localparam logic [9:0] E_RD  = 10'h200;
  localparam logic [9:0] E_AB  = 10'h100;
  localparam logic [9:0] E_AID = 10'h080;
  localparam logic [9:0] E_WBD = 10'h040;
  localparam logic [9:0] E_SHR = 10'h020;
  localparam logic [9:0] E_SHW = 10'h010;
  localparam logic [9:0] E_P1  = 10'h008;
  localparam logic [9:0] E_P0  = 10'h004;
  localparam logic [9:0] E_BSY = 10'h002;
  localparam logic [9:0] E_TO  = 10'h001;

  typedef struct {
    logic [8:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [9:0] observed();
    return {READ_DONE, send_abort, AllInvDone, write_back_done, SHR, SHW,
            peer_inv, busy, inv_timeout};
  endfunction

  task automatic drive(input logic [8:0] in);
    {reset, Cache_Sector_Fill, Invalidate, AdrRetry, abort_req,
     inv_ack[1], inv_ack[0], bus_snoop_rd, bus_snoop_wr} = in;
  endtask

  // Apply inputs for one cycle, then check outputs just after the sampling edge.
  task automatic step(input logic [8:0] in, input logic [9:0] exp, input string name);
    logic [9:0] got;
    drive(in);
    @(posedge clk);
    #1;
    got = observed();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b (RD,AB,AID,WBD,SHR,SHW,PI1,PI0,BSY,TO)",
               name, got, exp);
    end
  endtask

  task automatic add(input logic [8:0] in, input logic [9:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    drive(9'h000);

    // Reset, then fill with READ_LAT=4; snoop ordering.
    add(9'h000,    Z);
    add(9'h000,    Z);
    add(R | I_FIL, E_BSY);            // E0
    add(R,         E_BSY);
    add(R,         E_BSY);
    add(R,         E_BSY);
    add(R,         E_RD);             // E0+4
    add(R | I_SRD | I_SWR, E_SHW);
    add(R | I_SRD, E_SHR);
    add(R,         Z);

    // Fill aborted at E0+2.
    add(R | I_FIL, E_BSY);
    add(R,         E_BSY);
    add(R | I_ABT, E_AB);
    add(R,         Z);
    add(R,         Z);
    add(R,         Z);

    // Invalidate, acks at E0+1 and E0+3.
    add(R | I_INV, E_P1 | E_P0 | E_BSY);
    add(R | I_AK0, E_P1 | E_BSY);
    add(R,         E_P1 | E_BSY);
    add(R | I_AK1, E_AID);
    add(R,         Z);

    // AdrRetry and fill together: WB first, fill at next IDLE edge. Abort ignored in WB.
    add(R | I_ADR | I_FIL, E_BSY);    // E0
    add(R | I_ABT, E_BSY);
    add(R,         E_BSY);
    add(R,         E_WBD);            // E0+3
    add(R,         E_BSY);            // E0+4 fill accepted
    add(R,         E_BSY);
    add(R,         E_BSY);
    add(R,         E_BSY);
    add(R,         E_RD);             // E0+8
    add(R,         Z);

    // Repeated Invalidate during a fill merges into one pending request.
    add(R | I_FIL, E_BSY);
    add(R | I_INV, E_BSY);
    add(R | I_INV, E_BSY);
    add(R,         E_BSY);
    add(R,         E_RD);
    add(R,         E_P1 | E_P0 | E_BSY);
    add(R | I_AK0 | I_AK1, E_AID);
    add(R,         Z);
    add(R,         Z);

    // Invalidate beats fill; acks ignored outside INV.
    add(R | I_INV | I_FIL, E_P1 | E_P0 | E_BSY);
    add(R | I_AK0 | I_AK1, E_AID);
    add(R | I_AK0, E_BSY);            // fill accepted
    add(R,         E_BSY);
    add(R,         E_BSY);
    add(R,         E_BSY);
    add(R,         E_RD);
    add(R,         Z);

    // Reset mid-fill abandons the transaction silently.
    add(R | I_FIL, E_BSY);
    add(R,         E_BSY);
    add(9'h000,    Z);
    add(R,         Z);
    add(R,         Z);
    add(R,         Z);
    add(R,         Z);

    foreach (vecs[i])
      step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));

    // Invalidate with no acks: timeout after 15 edges, sticky flag.
    step(R | I_INV, E_P1 | E_P0 | E_BSY, "to_start");
    for (int k = 1; k < 15; k++)
      step(R, E_P1 | E_P0 | E_BSY, $sformatf("to_wait%0d", k));
    step(R, E_AID | E_TO, "to_expire");
    for (int k = 0; k < 3; k++)
      step(R, E_TO, $sformatf("to_hold%0d", k));
    step(9'h000, Z, "to_reset");
    step(R, Z, "to_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coherence_bus_responder.md
# coherence_bus_responder

Bus-side agent that answers the request strobes issued by a cache line's coherence controller, forming the other end of that handshake. It turns a sector-fill request into a timed `READ_DONE` (or `send_abort`), an invalidate request into a peer-invalidation broadcast that completes with `AllInvDone`, and an address-retry into a timed write-back that completes with `write_back_done`. It also registers bus snoop traffic into the `SHR`/`SHW` strobes the controller consumes. It sits between one cache controller and the shared bus/peer caches.

## Interface

Parameters:
- `READ_LAT`, 4, cycles from accepted fill to `READ_DONE`; legal range 1..15.
- `WB_LAT`, 3, cycles from accepted write-back to `write_back_done`; legal range 1..15.
- `NUM_PEERS`, 2, number of peer caches to invalidate; minimum 1.
- `INV_TIMEOUT`, 15, maximum cycles spent waiting for peer acks; legal range 1..255.

Ports:
- `clk` input 1: single clock; all logic runs on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `Cache_Sector_Fill` input 1: fill request strobe from the controller.
- `Invalidate` input 1: invalidate request strobe from the controller.
- `AdrRetry` input 1: write-back request strobe from the controller.
- `abort_req` input 1: bus abort; honoured only in FILL.
- `inv_ack` input NUM_PEERS: per-peer invalidate acknowledge.
- `bus_snoop_rd` input 1: a foreign read was observed on the bus.
- `bus_snoop_wr` input 1: a foreign write was observed on the bus.
- `READ_DONE` output 1: one-cycle fill completion.
- `send_abort` output 1: one-cycle fill abort.
- `AllInvDone` output 1: one-cycle invalidation completion.
- `write_back_done` output 1: one-cycle write-back completion.
- `SHR` output 1: registered snoop-read strobe.
- `SHW` output 1: registered snoop-write strobe.
- `peer_inv` output NUM_PEERS: per-peer invalidate request level.
- `busy` output 1: high whenever the state is not IDLE.
- `inv_timeout` output 1: sticky flag, set when an invalidation ends by timeout.

## Operation

- States: IDLE, FILL, INV, WB.
- All outputs are registered.
- Reset (`reset`=0 at an edge): state goes to IDLE, every output goes to 0, pending bits and counters are cleared. Reset mid-operation abandons the transaction and emits no completion strobe.
- Request selection in IDLE: candidates are the live strobes plus the pending bits. Priority is AdrRetry > Invalidate > Cache_Sector_Fill. The winner is accepted; every other live strobe sets its pending bit. The accepted type's pending bit is cleared.
- Strobes that arrive in any non-IDLE state, including the completion cycle, set their pending bits. Repeated strobes of the same type merge into one pending bit.
- FILL: a down-counter is loaded with READ_LAT.
  - `abort_req`=1 on any FILL edge: `send_abort` pulses, state returns to IDLE, and no `READ_DONE` is issued. Abort wins over simultaneous terminal count.
  - Counter expiry: `READ_DONE` pulses and state returns to IDLE.
- WB: a down-counter is loaded with WB_LAT. At expiry `write_back_done` pulses and state returns to IDLE. `abort_req` is ignored in WB.
- INV:
  - `peer_inv` is driven all-ones, and ack collection bits are cleared on entry.
  - Each `inv_ack[i]` sets sticky bit i; `peer_inv[i]` drops on the next edge.
  - Once all bits are set, `AllInvDone` pulses and state returns to IDLE.
  - If INV_TIMEOUT cycles elapse first, `AllInvDone` still pulses, `inv_timeout` sets (held until reset), and `peer_inv` clears.
  - `inv_ack` is ignored outside INV.
- Snoop path: runs independently of state. `bus_snoop_wr` at an edge gives `SHW`=1 for the following cycle. Otherwise `bus_snoop_rd` gives `SHR`=1. If both are high, only `SHW` is asserted.

## Timing

- A request accepted at edge E0 enters its state at E0.
- `READ_DONE` is high for exactly the cycle after edge E0+READ_LAT, unless an abort occurred.
- `send_abort` is high for the cycle after the edge that sampled `abort_req`.
- `write_back_done` is high for the cycle after edge E0+WB_LAT.
- `peer_inv` is high from E0. When the last ack is sampled at edge Ea, `AllInvDone` is high in the cycle after Ea and `busy` falls at Ea.
- Timeout: `AllInvDone` is high in the cycle after edge E0+INV_TIMEOUT.
- A pending request is accepted at the first edge at which state is IDLE, so back-to-back transactions have one IDLE cycle between them.
- Completion strobes never overlap each other.
- Snoop latency is 1 cycle.

## Test plan

- Reset held low for 2 cycles, then `Cache_Sector_Fill` pulse at E0 (READ_LAT=4) -> all outputs 0 during reset; `READ_DONE` high only in the cycle after E0+4; `busy` high for 4 cycles.
- Fill, then `abort_req` at E0+2 -> `send_abort` high in the cycle after E0+2; no `READ_DONE`; state returns to IDLE.
- `Invalidate` with NUM_PEERS=2, acks at E0+1 and E0+3 -> `peer_inv` goes 11, then 10, then 00; `AllInvDone` high in the cycle after E0+3; `inv_timeout` stays 0.
- `Invalidate` with no acks (INV_TIMEOUT=15) -> `AllInvDone` high in the cycle after E0+15; `inv_timeout`=1 held until reset.
- `AdrRetry` and `Cache_Sector_Fill` in the same cycle -> WB runs first and `write_back_done` is high after E0+3; the fill is accepted at the next IDLE edge and `READ_DONE` follows 4 edges later.
- `bus_snoop_rd` and `bus_snoop_wr` together, then `bus_snoop_rd` alone -> `SHW`=1, `SHR`=0 in the first cycle; `SHR`=1 in the next.
